// File: rtl/alu_exec_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Interface : alu_exec_if
// Brief     : Instruction handshake, ALU hookup, result and debug signals.
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
interface alu_exec_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [2:0]  in_op;
    logic        in_imm_en;
    logic [15:0] in_imm;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_f;
    logic        alu_zf;
    logic        alu_of;
    logic        done;
    logic [31:0] res_f;
    logic        res_zf;
    logic        res_of;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    // The execute stage itself.
    modport slave (
        input  in_valid, in_rs, in_rt, in_rd, in_op, in_imm_en, in_imm,
        input  alu_f, alu_zf, alu_of, dbg_addr,
        output in_ready, alu_a, alu_b, alu_op, done, res_f, res_zf, res_of,
        output dbg_data
    );

    // Instruction source, ALU and observer side.
    modport master (
        output in_valid, in_rs, in_rt, in_rd, in_op, in_imm_en, in_imm,
        output alu_f, alu_zf, alu_of, dbg_addr,
        input  in_ready, alu_a, alu_b, alu_op, done, res_f, res_zf, res_of,
        input  dbg_data
    );
endinterface
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : alu_exec_stage
// Brief    : Serial read/execute/writeback stage in front of a combinational
//            32-bit ALU, holding the 32x32 general register file.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module alu_exec_stage #(
    parameter bit          OF_BLOCK_WB = 1'b1,
    parameter logic [31:0] REG_INIT    = 32'h0
) (
    input  wire logic clk,
    input  wire logic rst_n,
    alu_exec_if.slave bus
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_read = 2'd1;
    localparam logic [1:0] c_st_exec = 2'd2;
    localparam logic [1:0] c_st_wb   = 2'd3;

    localparam logic [2:0] c_op_add  = 3'b100;
    localparam logic [2:0] c_op_sll  = 3'b111;

    logic [1:0]  r_state;
    logic [4:0]  r_rs;
    logic [4:0]  r_rt;
    logic [4:0]  r_rd;
    logic [2:0]  r_op;
    logic        r_imm_en;
    logic [15:0] r_imm;
    logic [31:0] r_regs [32];

    logic        r_in_ready;
    logic        r_done;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [2:0]  r_alu_op;
    logic [31:0] r_res_f;
    logic        r_res_zf;
    logic        r_res_of;

    logic [31:0] w_rs_data;
    logic [31:0] w_rt_data;
    logic [31:0] w_imm_ext;
    logic        w_of_kept;
    logic        w_wb_en;

    // r0 is hard-wired to zero on every read path.
    assign w_rs_data = (r_rs == 5'd0) ? 32'h0 : r_regs[r_rs];
    assign w_rt_data = (r_rt == 5'd0) ? 32'h0 : r_regs[r_rt];
    assign w_imm_ext = {{16{r_imm[15]}}, r_imm};

    assign w_of_kept = (r_op == c_op_add) || (r_op == c_op_sll);
    assign w_wb_en   = (r_rd != 5'd0) &&
                       !(OF_BLOCK_WB && (r_op == c_op_add) && r_res_of);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_in_ready <= 1'b1;
            r_done     <= 1'b0;
            r_alu_a    <= 32'h0;
            r_alu_b    <= 32'h0;
            r_alu_op   <= 3'b000;
            r_res_f    <= 32'h0;
            r_res_zf   <= 1'b0;
            r_res_of   <= 1'b0;
            r_rs       <= 5'd0;
            r_rt       <= 5'd0;
            r_rd       <= 5'd0;
            r_op       <= 3'b000;
            r_imm_en   <= 1'b0;
            r_imm      <= 16'h0;
            r_regs[0]  <= 32'h0;
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= REG_INIT;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (bus.in_valid) begin
                        r_rs       <= bus.in_rs;
                        r_rt       <= bus.in_rt;
                        r_rd       <= bus.in_rd;
                        r_op       <= bus.in_op;
                        r_imm_en   <= bus.in_imm_en;
                        r_imm      <= bus.in_imm;
                        r_in_ready <= 1'b0;
                        r_state    <= c_st_read;
                    end
                end
                c_st_read: begin
                    r_alu_a  <= w_rs_data;
                    r_alu_b  <= r_imm_en ? w_imm_ext : w_rt_data;
                    r_alu_op <= r_op;
                    r_state  <= c_st_exec;
                end
                c_st_exec: begin
                    // Only add and shift report a meaningful carry-out.
                    r_res_f  <= bus.alu_f;
                    r_res_zf <= bus.alu_zf;
                    r_res_of <= w_of_kept ? bus.alu_of : 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= c_st_wb;
                end
                c_st_wb: begin
                    if (w_wb_en) begin
                        r_regs[r_rd] <= r_res_f;
                    end
                    r_in_ready <= 1'b1;
                    r_state    <= c_st_idle;
                end
                default: begin
                    r_in_ready <= 1'b1;
                    r_state    <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.done     = r_done;
    assign bus.alu_a    = r_alu_a;
    assign bus.alu_b    = r_alu_b;
    assign bus.alu_op   = r_alu_op;
    assign bus.res_f    = r_res_f;
    assign bus.res_zf   = r_res_zf;
    assign bus.res_of   = r_res_of;

    // Debug port sees the committed register state, so a write in WB shows next cycle.
    assign bus.dbg_data = (bus.dbg_addr == 5'd0) ? 32'h0 : r_regs[bus.dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_alu_exec_stage
// Brief    : Two execute stages (write-back blocking on/off) driven in lockstep
//            against an instruction-level model and a reference ALU.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_alu_exec_stage;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        tb_valid;
    logic [4:0]  tb_rs;
    logic [4:0]  tb_rt;
    logic [4:0]  tb_rd;
    logic [2:0]  tb_op;
    logic        tb_imm_en;
    logic [15:0] tb_imm;
    logic [4:0]  tb_dbg;

    logic [1:0]        w_ready;
    logic [1:0]        w_done;
    logic [1:0][31:0]  w_dbg;
    logic [1:0][31:0]  w_res_f;
    logic [1:0]        w_res_zf;
    logic [1:0]        w_res_of;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU: returns {zf, of, f}; of is carry for add, borrow for sub,
    // last bit shifted out for shift-left of B by A.
    function automatic logic [33:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
        logic [32:0] t;
        t = '0;
        case (op)
            3'b000:  t = {1'b0, a & b};
            3'b001:  t = {1'b0, a | b};
            3'b010:  t = {1'b0, a ^ b};
            3'b011:  t = {1'b0, ~(a | b)};
            3'b100:  t = {1'b0, a} + {1'b0, b};
            3'b101:  t = {1'b0, a} - {1'b0, b};
            3'b110:  t = {32'b0, ($signed(a) < $signed(b))};
            default: t = {1'b0, b} << a[4:0];
        endcase
        return {(t[31:0] == 32'h0), t[32], t[31:0]};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam bit c_block = (g == 0);

        alu_exec_if bus ();
        logic [33:0] w_alu;

        assign bus.in_valid  = tb_valid;
        assign bus.in_rs     = tb_rs;
        assign bus.in_rt     = tb_rt;
        assign bus.in_rd     = tb_rd;
        assign bus.in_op     = tb_op;
        assign bus.in_imm_en = tb_imm_en;
        assign bus.in_imm    = tb_imm;
        assign bus.dbg_addr  = tb_dbg;
        assign w_alu         = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);
        assign bus.alu_f     = w_alu[31:0];
        assign bus.alu_of    = w_alu[32];
        assign bus.alu_zf    = w_alu[33];

        alu_exec_stage #(.OF_BLOCK_WB(c_block), .REG_INIT(32'h0)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        assign w_ready[g]  = bus.in_ready;
        assign w_done[g]   = bus.done;
        assign w_dbg[g]    = bus.dbg_data;
        assign w_res_f[g]  = bus.res_f;
        assign w_res_zf[g] = bus.res_zf;
        assign w_res_of[g] = bus.res_of;

        // Instruction-level model: the whole result is computed at accept time,
        // m_phase only tracks how many cycles ago that accept happened.
        int          m_phase = 0;
        logic [31:0] m_regs [32];
        logic [4:0]  m_rd = '0;
        logic [2:0]  m_op = '0;
        logic [31:0] m_a = '0, m_b = '0, m_f = '0;
        logic        m_zf = 1'b0, m_of = 1'b0;
        logic [31:0] m_alu_a = '0, m_alu_b = '0, m_res_f = '0;
        logic [2:0]  m_alu_op = '0;
        logic        m_res_zf = 1'b0, m_res_of = 1'b0;

        logic [31:0] w_m_a, w_m_b;
        logic [33:0] w_m_r;
        assign w_m_a = (tb_rs == 5'd0) ? 32'h0 : m_regs[tb_rs];
        assign w_m_b = tb_imm_en ? {{16{tb_imm[15]}}, tb_imm}
                                 : ((tb_rt == 5'd0) ? 32'h0 : m_regs[tb_rt]);
        assign w_m_r = alu_fn(w_m_a, w_m_b, tb_op);

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                m_phase  <= 0;
                m_alu_a  <= '0;
                m_alu_b  <= '0;
                m_alu_op <= '0;
                m_res_f  <= '0;
                m_res_zf <= 1'b0;
                m_res_of <= 1'b0;
                for (int i = 0; i < 32; i++) m_regs[i] <= 32'h0;
            end else begin
                case (m_phase)
                    0: if (tb_valid) begin
                        m_a     <= w_m_a;
                        m_b     <= w_m_b;
                        m_op    <= tb_op;
                        m_rd    <= tb_rd;
                        m_f     <= w_m_r[31:0];
                        m_zf    <= w_m_r[33];
                        m_of    <= (tb_op == 3'b100 || tb_op == 3'b111) ? w_m_r[32] : 1'b0;
                        m_phase <= 1;
                    end
                    1: begin
                        m_alu_a  <= m_a;
                        m_alu_b  <= m_b;
                        m_alu_op <= m_op;
                        m_phase  <= 2;
                    end
                    2: begin
                        m_res_f  <= m_f;
                        m_res_zf <= m_zf;
                        m_res_of <= m_of;
                        m_phase  <= 3;
                    end
                    default: begin
                        if (m_rd != 5'd0 && !(c_block && m_op == 3'b100 && m_of))
                            m_regs[m_rd] <= m_f;
                        m_phase <= 0;
                    end
                endcase
            end
        end

        always @(negedge clk) begin
            if (rst_n) begin
                chk($sformatf("u%0d in_ready", g), 32'(bus.in_ready), 32'(m_phase == 0));
                chk($sformatf("u%0d done", g),     32'(bus.done),     32'(m_phase == 3));
                chk($sformatf("u%0d alu_a", g),    bus.alu_a,         m_alu_a);
                chk($sformatf("u%0d alu_b", g),    bus.alu_b,         m_alu_b);
                chk($sformatf("u%0d alu_op", g),   32'(bus.alu_op),   32'(m_alu_op));
                chk($sformatf("u%0d res_f", g),    bus.res_f,         m_res_f);
                chk($sformatf("u%0d res_zf", g),   32'(bus.res_zf),   32'(m_res_zf));
                chk($sformatf("u%0d res_of", g),   32'(bus.res_of),   32'(m_res_of));
                chk($sformatf("u%0d dbg_data", g), bus.dbg_data,
                    (tb_dbg == 5'd0) ? 32'h0 : m_regs[tb_dbg]);
            end
        end
    end

    always @(negedge clk) if (w_done[0]) done_cnt++;

    // Offer an instruction and hold it until accepted; returns 1 ns after the accept edge.
    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [2:0] op, input logic imm_en, input logic [15:0] imm);
        int  k;
        bit  got;
        tb_rs = rs; tb_rt = rt; tb_rd = rd; tb_op = op; tb_imm_en = imm_en; tb_imm = imm;
        tb_valid = 1'b1;
        k   = 0;
        got = 1'b0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if (w_ready[0]) begin
                @(posedge clk);
                #1;
                got = 1'b1;
            end
        end
        tb_valid = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: no in_ready within %0d cycles", k);
        end
    endtask

    // Counts negedges from the accept until done is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!w_done[0] && lat < 20);
        if (!w_done[0]) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles", lat);
        end
    endtask

    task automatic to_idle();
        @(posedge clk);
        #1;
    endtask

    task automatic res_chk(input string name, input logic [31:0] f, input logic zf, input logic of);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s u%0d res_f", name, g),  w_res_f[g],         f);
            chk($sformatf("%s u%0d res_zf", name, g), 32'(w_res_zf[g]),   32'(zf));
            chk($sformatf("%s u%0d res_of", name, g), 32'(w_res_of[g]),   32'(of));
        end
    endtask

    task automatic dbg_chk(input string name, input logic [4:0] addr,
                           input logic [31:0] exp0, input logic [31:0] exp1);
        tb_dbg = addr;
        #1;
        chk($sformatf("%s u0", name), w_dbg[0], exp0);
        chk($sformatf("%s u1", name), w_dbg[1], exp1);
    endtask

    initial begin
        int lat;
        int acc;
        int dc;
        tb_valid = 1'b0; tb_rs = '0; tb_rt = '0; tb_rd = '0; tb_op = '0;
        tb_imm_en = 1'b0; tb_imm = '0; tb_dbg = '0;
        rst_n = 1'b1;

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("reset in_ready u0", 32'(w_ready[0]), 32'd1);
        chk("reset in_ready u1", 32'(w_ready[1]), 32'd1);
        chk("reset done u0", 32'(w_done[0]), 32'd0);
        chk("reset done u1", 32'(w_done[1]), 32'd0);
        dbg_chk("reset r0", 5'd0, 32'h0, 32'h0);
        dbg_chk("reset r1", 5'd1, 32'h0, 32'h0);
        dbg_chk("reset r31", 5'd31, 32'h0, 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        to_idle();

        // r1 = r0 + 5
        issue(5'd0, 5'd0, 5'd1, 3'b100, 1'b1, 16'h0005);
        wait_done(lat);
        chk("imm add latency", 32'(lat), 32'd3);
        res_chk("imm add", 32'h5, 1'b0, 1'b0);
        to_idle();
        dbg_chk("imm add r1", 5'd1, 32'h5, 32'h5);

        // r2 = r1 + 0xFFFFFFFF carries out: blocked only when OF_BLOCK_WB=1
        issue(5'd1, 5'd0, 5'd2, 3'b100, 1'b1, 16'hFFFF);
        wait_done(lat);
        res_chk("carry add", 32'h4, 1'b0, 1'b1);
        to_idle();
        dbg_chk("carry add r2", 5'd2, 32'h0, 32'h4);

        // r1 - r1 into r0
        issue(5'd1, 5'd1, 5'd0, 3'b101, 1'b0, 16'h0);
        wait_done(lat);
        res_chk("zero sub", 32'h0, 1'b1, 1'b0);
        to_idle();
        dbg_chk("zero sub r0", 5'd0, 32'h0, 32'h0);

        // r4 = 1, then r3 = 0xFFFFFFFF << r4
        issue(5'd0, 5'd0, 5'd4, 3'b100, 1'b1, 16'h0001);
        wait_done(lat);
        to_idle();
        issue(5'd4, 5'd0, 5'd3, 3'b111, 1'b1, 16'hFFFF);
        wait_done(lat);
        res_chk("shift", 32'hFFFF_FFFE, 1'b0, 1'b1);
        to_idle();
        dbg_chk("shift r3", 5'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFE);

        // 0 - 5 borrows, but sub never reports it
        issue(5'd0, 5'd1, 5'd6, 3'b101, 1'b0, 16'h0);
        wait_done(lat);
        res_chk("sub borrow", 32'hFFFF_FFFB, 1'b0, 1'b0);
        to_idle();
        dbg_chk("sub r6", 5'd6, 32'hFFFF_FFFB, 32'hFFFF_FFFB);

        // r3 & r1
        issue(5'd3, 5'd1, 5'd9, 3'b000, 1'b0, 16'h0);
        wait_done(lat);
        res_chk("and", 32'h4, 1'b0, 1'b0);
        to_idle();

        // Negative immediate is sign-extended
        issue(5'd0, 5'd0, 5'd8, 3'b100, 1'b1, 16'h8000);
        wait_done(lat);
        res_chk("sext", 32'hFFFF_8000, 1'b0, 1'b0);
        to_idle();

        // in_valid held high for 16 cycles: r5 += 1 each accept
        tb_rs = 5'd5; tb_rt = 5'd0; tb_rd = 5'd5; tb_op = 3'b100; tb_imm_en = 1'b1; tb_imm = 16'h1;
        tb_valid = 1'b1;
        acc = 0;
        repeat (16) begin
            @(negedge clk);
            if (w_ready[0]) acc++;
            @(posedge clk);
        end
        #1 tb_valid = 1'b0;
        chk("busy accepts", 32'(acc), 32'd4);
        dbg_chk("busy r5", 5'd5, 32'h4, 32'h4);
        to_idle();

        // r7 = 7, then reset while r7 = r7 + 1 is in EXEC
        issue(5'd0, 5'd0, 5'd7, 3'b100, 1'b1, 16'h0007);
        wait_done(lat);
        to_idle();
        dbg_chk("pre-reset r7", 5'd7, 32'h7, 32'h7);
        issue(5'd7, 5'd0, 5'd7, 3'b100, 1'b1, 16'h0001);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        dc = done_cnt;
        chk("midop in_ready u0", 32'(w_ready[0]), 32'd1);
        chk("midop in_ready u1", 32'(w_ready[1]), 32'd1);
        chk("midop done u0", 32'(w_done[0]), 32'd0);
        chk("midop done u1", 32'(w_done[1]), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("midop no done", 32'(done_cnt), 32'(dc));
        dbg_chk("midop r7", 5'd7, 32'h0, 32'h0);

        // Stage is usable again after the reset
        to_idle();
        issue(5'd0, 5'd0, 5'd10, 3'b100, 1'b1, 16'h0003);
        wait_done(lat);
        chk("post-reset latency", 32'(lat), 32'd3);
        res_chk("post-reset", 32'h3, 1'b0, 1'b0);
        to_idle();
        dbg_chk("post-reset r10", 5'd10, 32'h3, 32'h3);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
